alu_acc_fsm: RTL and testbench

ALU_ACC_FSM -- requirements
Module: alu_acc_fsm

---
 rtl/alu_acc_fsm.sv | 185 ++++++++++++++++++
 tb/tb_alu_acc_fsm.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_fsm.sv
// alu_acc_fsm: accumulator ALU sequenced by a four-state FSM (OFF/READY/RUN/ERROR).
//
// A command (op, load flag, operand) is accepted in READY, evaluated against the
// accumulator during the single RUN cycle, and written back at the closing edge
// of RUN together with a one-cycle res_valid pulse. Overflow either traps into
// ERROR with a wrapped result (SAT=0) or saturates and continues (SAT=1); in
// both cases the sticky ovf flag is set.
//
// Ports:
//   clk_i        rising-edge clock for all state
//   rst_i        asynchronous active-high reset
//   en_i         power enable (1 leaves OFF, 0 returns to OFF)
//   cmd_valid_i  command request
//   cmd_ready_o  block accepts a command this cycle (READY only)
//   cmd_op_i     000 AND, 001 OR, 010 XOR, 011 NOT(acc), 100 ADD, 101 SUB, 110 MUL, 111 PASS
//   cmd_load_i   load acc with operand, overrides cmd_op_i
//   operand_i    second operand (acc is always the first)
//   clr_err_i    clears ERROR and ovf
//   acc_o        accumulator value
//   res_valid_o  one-cycle pulse when acc holds a new result
//   ovf_o        sticky overflow flag
//   state_o      registered FSM state: 00 OFF, 01 READY, 10 RUN, 11 ERROR
module alu_acc_fsm #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic             cmd_load_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             res_valid_o,
    output logic             ovf_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             res_valid_q, res_valid_d;
    logic [2:0]       op_q, op_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;

    // Datapath works only on the captured command, so operand_i may change
    // freely while RUN is in progress.
    logic [WIDTH:0]         sum_w;
    logic [WIDTH:0]         diff_w;
    logic [2*WIDTH-1:0]     prod_w;
    logic [WIDTH-1:0]       result_w;
    logic                   flag_w;

    assign sum_w  = {1'b0, acc_q} + {1'b0, opnd_q};
    // Top bit of the extended difference is the unsigned borrow (acc < operand).
    assign diff_w = {1'b0, acc_q} - {1'b0, opnd_q};
    assign prod_w = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, opnd_q};

    always_comb begin
        result_w = '0;
        flag_w   = 1'b0;
        if (load_q) begin
            result_w = opnd_q;
        end else begin
            case (op_q)
                OP_AND:  result_w = acc_q & opnd_q;
                OP_OR:   result_w = acc_q | opnd_q;
                OP_XOR:  result_w = acc_q ^ opnd_q;
                OP_NOT:  result_w = ~acc_q;
                OP_ADD: begin
                    flag_w   = sum_w[WIDTH];
                    result_w = (SAT && flag_w) ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
                end
                OP_SUB: begin
                    flag_w   = diff_w[WIDTH];
                    result_w = (SAT && flag_w) ? {WIDTH{1'b0}} : diff_w[WIDTH-1:0];
                end
                OP_MUL: begin
                    flag_w   = |prod_w[2*WIDTH-1:WIDTH];
                    result_w = (SAT && flag_w) ? {WIDTH{1'b1}} : prod_w[WIDTH-1:0];
                end
                OP_PASS: result_w = opnd_q;
                default: result_w = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        res_valid_d = 1'b0;
        op_d        = op_q;
        load_d      = load_q;
        opnd_d      = opnd_q;
        case (state_q)
            S_OFF: begin
                if (clr_err_i) ovf_d = 1'b0;
                if (en_i)      state_d = S_READY;
            end
            S_READY: begin
                if (clr_err_i) ovf_d = 1'b0;
                // An accepted command wins over a simultaneous power-down.
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    load_d  = cmd_load_i;
                    opnd_d  = operand_i;
                    state_d = S_RUN;
                end else if (!en_i) begin
                    state_d = S_OFF;
                end
            end
            S_RUN: begin
                acc_d       = result_w;
                res_valid_d = 1'b1;
                ovf_d       = ovf_q | flag_w;
                if (flag_w && !SAT) begin
                    state_d = S_ERROR;
                end else if (!en_i) begin
                    state_d = S_OFF;
                end else begin
                    state_d = S_READY;
                end
            end
            S_ERROR: begin
                if (!en_i) begin
                    state_d = S_OFF;
                    ovf_d   = 1'b0;
                end else if (clr_err_i) begin
                    state_d = S_READY;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Asynchronous reset also aborts a RUN in flight: nothing is written back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_OFF;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            op_q        <= '0;
            load_q      <= 1'b0;
            opnd_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            op_q        <= op_d;
            load_q      <= load_d;
            opnd_q      <= opnd_d;
        end
    end

    assign cmd_ready_o = (state_q == S_READY);
    assign acc_o       = acc_q;
    assign res_valid_o = res_valid_q;
    assign ovf_o       = ovf_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_alu_acc_fsm.sv
// Testbench for alu_acc_fsm: one wrapping (SAT=0) and one saturating (SAT=1)
// instance share all inputs; each is compared every cycle against its own
// behavioural model, plus table vectors and directed corner-case sequences.
module tb_alu_acc_fsm;
    localparam int W = 8;
    localparam logic [1:0] M_OFF = 2'd0, M_READY = 2'd1, M_RUN = 2'd2, M_ERROR = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_load = 1'b0;
    logic         clr_err = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] operand = '0;

    logic         cmd_ready_w [2];
    logic [W-1:0] acc_w [2];
    logic         res_valid_w [2];
    logic         ovf_w [2];
    logic [1:0]   state_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_acc_fsm #(.WIDTH(W), .SAT(1'b0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_w[0]), .cmd_op_i(cmd_op), .cmd_load_i(cmd_load),
        .operand_i(operand), .clr_err_i(clr_err), .acc_o(acc_w[0]),
        .res_valid_o(res_valid_w[0]), .ovf_o(ovf_w[0]), .state_o(state_w[0])
    );

    alu_acc_fsm #(.WIDTH(W), .SAT(1'b1)) u_sat (
        .clk_i(clk), .rst_i(rst), .en_i(en), .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_w[1]), .cmd_op_i(cmd_op), .cmd_load_i(cmd_load),
        .operand_i(operand), .clr_err_i(clr_err), .acc_o(acc_w[1]),
        .res_valid_o(res_valid_w[1]), .ovf_o(ovf_w[1]), .state_o(state_w[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] st;
        int         acc;
        logic       ovf;
        logic       rv;
        int         op;
        logic       ld;
        int         opnd;
    } mdl_t;

    mdl_t mdl [2];

    // Result of a captured command computed with plain integer arithmetic.
    function automatic void alu_ref(input mdl_t s, input bit sat, output int r, output bit f);
        int a = s.acc;
        int b = s.opnd;
        f = 1'b0;
        if (s.ld) begin
            r = b;
        end else begin
            case (s.op)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                3: r = 255 - a;
                4: begin r = a + b; if (r > 255) begin f = 1'b1; r = sat ? 255 : r - 256; end end
                5: begin r = a - b; if (r < 0)   begin f = 1'b1; r = sat ? 0   : r + 256; end end
                6: begin r = a * b; if (r > 255) begin f = 1'b1; r = sat ? 255 : r % 256; end end
                default: r = b;
            endcase
        end
    endfunction

    // One clock edge of the specified behaviour, using the inputs now applied.
    function automatic mdl_t model_step(input mdl_t s, input bit sat);
        mdl_t n = s;
        int   r;
        bit   f;
        n.rv = 1'b0;
        if (s.st == M_OFF) begin
            if (clr_err) n.ovf = 1'b0;
            if (en) n.st = M_READY;
        end else if (s.st == M_READY) begin
            if (clr_err) n.ovf = 1'b0;
            if (cmd_valid) begin
                n.op = int'(cmd_op); n.ld = cmd_load; n.opnd = int'(operand); n.st = M_RUN;
            end else if (!en) begin
                n.st = M_OFF;
            end
        end else if (s.st == M_RUN) begin
            alu_ref(s, sat, r, f);
            n.acc = r;
            n.rv  = 1'b1;
            n.ovf = s.ovf | f;
            if (f && !sat)  n.st = M_ERROR;
            else if (!en)   n.st = M_OFF;
            else            n.st = M_READY;
        end else begin
            if (!en) begin n.st = M_OFF; n.ovf = 1'b0; end
            else if (clr_err) begin n.st = M_READY; n.ovf = 1'b0; end
        end
        return n;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d_state", i), int'(state_w[i]), int'(mdl[i].st));
            chk($sformatf("dut%0d_acc", i), int'(acc_w[i]), mdl[i].acc);
            chk($sformatf("dut%0d_ovf", i), int'(ovf_w[i]), int'(mdl[i].ovf));
            chk($sformatf("dut%0d_res_valid", i), int'(res_valid_w[i]), int'(mdl[i].rv));
            chk($sformatf("dut%0d_cmd_ready", i), int'(cmd_ready_w[i]), int'(mdl[i].st == M_READY));
        end
    endtask

    task automatic cycle();
        mdl[0] = model_step(mdl[0], 1'b0);
        mdl[1] = model_step(mdl[1], 1'b1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Assert reset away from a clock edge, check it acts immediately, hold
    // it across one edge, release it away from the edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) mdl[i] = '{st: M_OFF, acc: 0, ovf: 1'b0, rv: 1'b0, op: 0, ld: 1'b0, opnd: 0};
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic [2:0] op, input logic [7:0] v);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; operand = v;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        $display("txn ld=%0d op=%0d operand=%02h -> wrap: acc=%02h st=%0d ovf=%0d | sat: acc=%02h st=%0d ovf=%0d",
                 ld, op, v, acc_w[0], state_w[0], ovf_w[0], acc_w[1], state_w[1], ovf_w[1]);
    endtask

    task automatic clear_cycle();
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [7:0] opnd;
        logic [7:0] acc0; logic ovf0; logic [1:0] st0;
        logic [7:0] acc1; logic ovf1; logic [1:0] st1;
    } vec_t;

    vec_t vecs [19];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 8'h0F, 8'h0F, 1'b0, 2'd1, 8'h0F, 1'b0, 2'd1};
        vecs[1]  = '{1'b0, 3'd4, 8'hF0, 8'hFF, 1'b0, 2'd1, 8'hFF, 1'b0, 2'd1};
        vecs[2]  = '{1'b0, 3'd4, 8'h01, 8'h00, 1'b1, 2'd3, 8'hFF, 1'b1, 2'd1};
        vecs[3]  = '{1'b1, 3'd0, 8'h20, 8'h20, 1'b0, 2'd1, 8'h20, 1'b0, 2'd1};
        vecs[4]  = '{1'b0, 3'd6, 8'h10, 8'h00, 1'b1, 2'd3, 8'hFF, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 3'd0, 8'h03, 8'h03, 1'b0, 2'd1, 8'h03, 1'b0, 2'd1};
        vecs[6]  = '{1'b0, 3'd5, 8'h05, 8'hFE, 1'b1, 2'd3, 8'h00, 1'b1, 2'd1};
        vecs[7]  = '{1'b1, 3'd0, 8'hA5, 8'hA5, 1'b0, 2'd1, 8'hA5, 1'b0, 2'd1};
        vecs[8]  = '{1'b0, 3'd0, 8'h3C, 8'h24, 1'b0, 2'd1, 8'h24, 1'b0, 2'd1};
        vecs[9]  = '{1'b0, 3'd1, 8'h81, 8'hA5, 1'b0, 2'd1, 8'hA5, 1'b0, 2'd1};
        vecs[10] = '{1'b0, 3'd2, 8'hFF, 8'h5A, 1'b0, 2'd1, 8'h5A, 1'b0, 2'd1};
        vecs[11] = '{1'b0, 3'd3, 8'h33, 8'hA5, 1'b0, 2'd1, 8'hA5, 1'b0, 2'd1};
        vecs[12] = '{1'b0, 3'd7, 8'h77, 8'h77, 1'b0, 2'd1, 8'h77, 1'b0, 2'd1};
        vecs[13] = '{1'b0, 3'd5, 8'h07, 8'h70, 1'b0, 2'd1, 8'h70, 1'b0, 2'd1};
        vecs[14] = '{1'b0, 3'd6, 8'h02, 8'hE0, 1'b0, 2'd1, 8'hE0, 1'b0, 2'd1};
        vecs[15] = '{1'b0, 3'd4, 8'h1F, 8'hFF, 1'b0, 2'd1, 8'hFF, 1'b0, 2'd1};
        vecs[16] = '{1'b1, 3'd4, 8'hFF, 8'hFF, 1'b0, 2'd1, 8'hFF, 1'b0, 2'd1};
        vecs[17] = '{1'b0, 3'd6, 8'h01, 8'hFF, 1'b0, 2'd1, 8'hFF, 1'b0, 2'd1};
        vecs[18] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b0, 2'd1, 8'h00, 1'b0, 2'd1};

        // Reset, stay OFF while en=0, then power up.
        #3;
        do_reset();
        cycle();
        cycle();
        chk("off_hold_state", int'(state_w[0]), 0);
        en = 1'b1;
        cycle();
        chk("powerup_state", int'(state_w[0]), 1);
        chk("powerup_ready", int'(cmd_ready_w[0]), 1);
        chk("powerup_acc", int'(acc_w[0]), 0);
        chk("powerup_ovf", int'(ovf_w[0]), 0);

        // Table vectors: result is visible right after the second edge.
        for (int k = 0; k < 19; k++) begin
            issue(vecs[k].ld, vecs[k].op, vecs[k].opnd);
            chk($sformatf("vec%0d_wrap_acc", k), int'(acc_w[0]), int'(vecs[k].acc0));
            chk($sformatf("vec%0d_wrap_ovf", k), int'(ovf_w[0]), int'(vecs[k].ovf0));
            chk($sformatf("vec%0d_wrap_state", k), int'(state_w[0]), int'(vecs[k].st0));
            chk($sformatf("vec%0d_wrap_rv", k), int'(res_valid_w[0]), 1);
            chk($sformatf("vec%0d_sat_acc", k), int'(acc_w[1]), int'(vecs[k].acc1));
            chk($sformatf("vec%0d_sat_ovf", k), int'(ovf_w[1]), int'(vecs[k].ovf1));
            chk($sformatf("vec%0d_sat_state", k), int'(state_w[1]), int'(vecs[k].st1));
            chk($sformatf("vec%0d_sat_rv", k), int'(res_valid_w[1]), 1);
            clear_cycle();
            chk($sformatf("vec%0d_rv_drop", k), int'(res_valid_w[0]), 0);
        end

        // Wrap overflow traps; commands ignored in ERROR; clr_err recovers.
        issue(1'b1, 3'd0, 8'hFF);
        issue(1'b0, 3'd4, 8'h01);
        chk("trap_state", int'(state_w[0]), 3);
        chk("trap_ready", int'(cmd_ready_w[0]), 0);
        chk("trap_acc", int'(acc_w[0]), 8'h00);
        chk("trap_ovf", int'(ovf_w[0]), 1);
        cmd_valid = 1'b1; cmd_load = 1'b1; operand = 8'h55;
        cycle();
        cycle();
        cmd_valid = 1'b0;
        chk("error_ignore_acc", int'(acc_w[0]), 8'h00);
        chk("error_ignore_state", int'(state_w[0]), 3);
        cycle();
        clear_cycle();
        chk("clr_state", int'(state_w[0]), 1);
        chk("clr_ovf", int'(ovf_w[0]), 0);
        chk("clr_acc", int'(acc_w[0]), 8'h00);

        // Saturating MUL, then SUB underflow keeps ovf sticky.
        issue(1'b1, 3'd0, 8'h20);
        issue(1'b0, 3'd6, 8'h10);
        chk("sat_mul_acc", int'(acc_w[1]), 8'hFF);
        chk("sat_mul_ovf", int'(ovf_w[1]), 1);
        chk("sat_mul_state", int'(state_w[1]), 1);
        issue(1'b1, 3'd0, 8'h03);
        issue(1'b0, 3'd5, 8'h05);
        chk("sat_sub_acc", int'(acc_w[1]), 8'h00);
        chk("sat_sub_ovf", int'(ovf_w[1]), 1);
        clear_cycle();

        // Borrow traps; en=0 from ERROR goes OFF, clears ovf, keeps acc.
        issue(1'b1, 3'd0, 8'h05);
        issue(1'b0, 3'd5, 8'h07);
        chk("borrow_acc", int'(acc_w[0]), 8'hFE);
        chk("borrow_state", int'(state_w[0]), 3);
        en = 1'b0;
        cycle();
        chk("err_off_state", int'(state_w[0]), 0);
        chk("err_off_ovf", int'(ovf_w[0]), 0);
        chk("err_off_acc", int'(acc_w[0]), 8'hFE);
        en = 1'b1;
        cycle();

        // Reset during RUN aborts the operation.
        cmd_valid = 1'b1; cmd_load = 1'b1; operand = 8'h42;
        cycle();
        cmd_valid = 1'b0;
        chk("run_entered", int'(state_w[0]), 2);
        do_reset();
        chk("abort_acc", int'(acc_w[0]), 0);
        chk("abort_state", int'(state_w[0]), 0);
        chk("abort_rv", int'(res_valid_w[0]), 0);
        en = 1'b0;
        cycle();
        chk("abort_no_rv", int'(res_valid_w[0]), 0);
        en = 1'b1;
        cycle();

        // en=0 during RUN still writes the result, then goes OFF.
        cmd_valid = 1'b1; cmd_load = 1'b1; operand = 8'h33;
        cycle();
        cmd_valid = 1'b0; en = 1'b0;
        cycle();
        chk("run_off_acc", int'(acc_w[0]), 8'h33);
        chk("run_off_rv", int'(res_valid_w[0]), 1);
        chk("run_off_state", int'(state_w[0]), 0);
        en = 1'b1;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            en        = ($urandom_range(0, 15) != 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_load  = ($urandom_range(0, 4) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            operand   = 8'($urandom_range(0, 255));
            clr_err   = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
